ripple_carry_adder: RTL and testbench
=====================================

Name: ripple_carry_adder

Overview:
Registered, parameterizable ripple-carry adder built from a chain of single-bit full-adder stages. Adds two WIDTH-bit unsigned operands plus a carry-in, producing a WIDTH-bit sum and a carry-out one clock after the operands are presented. It is a small arithmetic leaf block for datapaths that want a registered add with an explicit carry chain rather than an inferred adder.

Parameters:
WIDTH, 2, operand and sum width in bits (legal range 1..64).

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_1  input  WIDTH  operand A, unsigned
in_2  input  WIDTH  operand B, unsigned
c_in  input  1  carry into the least significant stage
in_valid  input  1  operands and c_in are valid this cycle
sum  output  WIDTH  registered sum, modulo 2^WIDTH
c_out  output  1  registered carry out of the most significant stage
overflow  output  1  registered two's-complement signed overflow flag
out_valid  output  1  sum, c_out and overflow hold a new result

Behaviour:
- Vector ordering: all multi-bit ports are declared [0:WIDTH-1]. Index 0 is the MSB and index WIDTH-1 is the LSB. The numeric value is the usual binary reading, left to right, MSB first.
- Combinational core: WIDTH full-adder stages, each with s = a^b^ci and co = (a&b)|(ci&(a^b)).
  - The LSB stage (index WIDTH-1) takes c_in as its carry in.
  - Stage k's carry out feeds stage k-1.
  - The carry out of stage 0 is the raw c_out.
  - The carry must ripple stage-to-stage; no carry-lookahead or inferred "+" for the core.
- Result: {c_out,sum} = in_1 + in_2 + c_in, exactly WIDTH+1 bits, with no truncation other than sum wrapping modulo 2^WIDTH.
- overflow = carry into stage 0 XOR carry out of stage 0. It is meaningful only when the operands are read as signed.
- Latency: 1 cycle.
  - On a rising clk edge with in_valid=1, the sum, c_out and overflow registers load the combinational result, and out_valid is set to 1.
  - On an edge with in_valid=0, out_valid goes to 0 and sum/c_out/overflow hold their previous values.
- Throughput: one addition per cycle; back-to-back valid inputs produce back-to-back results.
- Reset: while rst=1, regardless of clk, sum=0, c_out=0, overflow=0 and out_valid=0.
  - Reset asserted mid-stream discards any in-flight result.
  - After rst deasserts, the first valid result appears one edge after in_valid is sampled high.
- No backpressure: results are not held pending acceptance. Downstream logic must capture them in the out_valid cycle.
- Inputs are sampled only at the clock edge; glitches between edges have no effect.

Test Plan:
- Reset, then WIDTH=2 sequence, each with in_valid=1, one per cycle; each result one cycle later with out_valid=1:
  - in_1=00, in_2=10, c_in=1 -> sum=11, c_out=0
  - in_1=01, in_2=10, c_in=1 -> sum=00, c_out=1
  - in_1=10, in_2=11, c_in=0 -> sum=01, c_out=1
  - in_1=11, in_2=10, c_in=1 -> sum=10, c_out=1
  - in_1=00, in_2=11, c_in=0 -> sum=11, c_out=0
- Full carry ripple, WIDTH=2: in_1=11, in_2=00, c_in=1 -> sum=00, c_out=1, overflow=0. Then in_1=01, in_2=01, c_in=0 -> sum=10, c_out=0, overflow=1.
- Valid gating: present in_1=01, in_2=01, c_in=0 with in_valid=0 -> out_valid=0 and sum/c_out unchanged from the prior result. Next cycle with in_valid=1 -> sum=10, out_valid=1.
- Async reset mid-stream: assert rst between clock edges right after a result is registered -> sum=00, c_out=0, overflow=0, out_valid=0 immediately, without waiting for a clock edge. These hold until rst deasserts and a new valid input is clocked.
- Exhaustive at WIDTH=2 and WIDTH=4: all in_1, in_2, c_in combinations, back-to-back -> every {c_out,sum} equals in_1+in_2+c_in, and overflow matches the signed-overflow model.
- WIDTH=8 corner cases:
  - in_1=FF, in_2=01, c_in=0 -> sum=00, c_out=1
  - in_1=7F, in_2=00, c_in=1 -> sum=80, c_out=0, overflow=1

Source files
------------

// File: rtl/ripple_carry_adder_if.sv
// ripple_carry_adder_if: operand/result bundle for ripple_carry_adder.
//   in_1, in_2 [0:WIDTH-1] : operands (index 0 = MSB)
//   c_in, in_valid         : carry into LSB stage, operands valid
//   sum [0:WIDTH-1]        : registered sum
//   c_out, overflow        : registered carry out / signed overflow
//   out_valid              : result registers hold a new result
// master drives operands, slave (the adder) drives results.
interface ripple_carry_adder_if #(
  parameter int WIDTH = 2
);
  logic [0:WIDTH-1] in_1;
  logic [0:WIDTH-1] in_2;
  logic             c_in;
  logic             in_valid;
  logic [0:WIDTH-1] sum;
  logic             c_out;
  logic             overflow;
  logic             out_valid;

  modport master (
    output in_1, in_2, c_in, in_valid,
    input  sum, c_out, overflow, out_valid
  );

  modport slave (
    input  in_1, in_2, c_in, in_valid,
    output sum, c_out, overflow, out_valid
  );
endinterface

// File: rtl/ripple_carry_adder.sv
// ripple_carry_adder: registered WIDTH-bit ripple-carry adder, 1-cycle latency.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset, clears results and out_valid
//   io  : ripple_carry_adder_if.slave (operands in, registered results out)
// Vectors are [0:WIDTH-1]; index 0 is the MSB, so the carry ripples from
// index WIDTH-1 down to index 0.

// Single-bit full-adder stage.
module rca_full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module ripple_carry_adder #(
  parameter int WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  ripple_carry_adder_if.slave  io
);
  // carry[k+1] is the carry into stage k; carry[WIDTH] is c_in,
  // carry[0] is the carry out of the MSB stage.
  logic [0:WIDTH]   carry;
  logic [0:WIDTH-1] s_comb;

  logic [0:WIDTH-1] sum_q;
  logic             c_out_q;
  logic             ovf_q;
  logic             vld_q;

  assign carry[WIDTH] = io.c_in;

  for (genvar k = 0; k < WIDTH; k++) begin : g_stage
    rca_full_adder u_fa (
      .a  (io.in_1[k]),
      .b  (io.in_2[k]),
      .ci (carry[k+1]),
      .s  (s_comb[k]),
      .co (carry[k])
    );
  end

  // Results load only on valid cycles; otherwise they hold and only
  // out_valid drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      vld_q <= io.in_valid;
      if (io.in_valid) begin
        sum_q   <= s_comb;
        c_out_q <= carry[0];
        // Signed overflow: carry into MSB stage differs from carry out of it.
        ovf_q   <= carry[0] ^ carry[1];
      end
    end
  end

  assign io.sum       = sum_q;
  assign io.c_out     = c_out_q;
  assign io.overflow  = ovf_q;
  assign io.out_valid = vld_q;
endmodule

// File: tb/tb_ripple_carry_adder.sv
// tb_ripple_carry_adder: directed + exhaustive checks of ripple_carry_adder
// at WIDTH=2, 4 and 8, sharing one clock and reset.
module tb_ripple_carry_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  ripple_carry_adder_if #(.WIDTH(2)) if2 ();
  ripple_carry_adder_if #(.WIDTH(4)) if4 ();
  ripple_carry_adder_if #(.WIDTH(8)) if8 ();

  ripple_carry_adder #(.WIDTH(2)) u_dut2 (.clk(clk), .rst(rst), .io(if2.slave));
  ripple_carry_adder #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .io(if4.slave));
  ripple_carry_adder #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .io(if8.slave));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Signed-overflow reference: true signed result out of range.
  function automatic bit ovf_model(input int a, input int b, input int ci, input int w);
    int sa, sb, t;
    sa = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
    sb = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
    t  = sa + sb + ci;
    return (t > (1 << (w - 1)) - 1) || (t < -(1 << (w - 1)));
  endfunction

  // Drive one cycle of operands, clock, sample 1 time unit after the edge.
  task automatic step2(input logic [1:0] a, input logic [1:0] b, input logic ci, input logic v);
    if2.in_1 = a; if2.in_2 = b; if2.c_in = ci; if2.in_valid = v;
    @(posedge clk); #1;
  endtask

  task automatic exp2(input string tag, input logic [1:0] s, input logic co, input logic vld);
    chk({tag, ".sum"}, 64'(if2.sum), 64'(s));
    chk({tag, ".c_out"}, 64'(if2.c_out), 64'(co));
    chk({tag, ".out_valid"}, 64'(if2.out_valid), 64'(vld));
  endtask

  initial begin
    logic [3:0] a4, b4;
    logic [4:0] r4;
    logic [2:0] r2;
    logic [1:0] a2, b2;

    if2.in_1 = '0; if2.in_2 = '0; if2.c_in = 0; if2.in_valid = 0;
    if4.in_1 = '0; if4.in_2 = '0; if4.c_in = 0; if4.in_valid = 0;
    if8.in_1 = '0; if8.in_2 = '0; if8.c_in = 0; if8.in_valid = 0;

    // Reset state
    #3;
    exp2("rst", 2'b00, 1'b0, 1'b0);
    chk("rst.ovf", 64'(if2.overflow), 64'd0);
    chk("rst.w8.sum", 64'(if8.sum), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Directed WIDTH=2 sequence, back-to-back
    step2(2'b00, 2'b10, 1'b1, 1'b1); exp2("seq0", 2'b11, 1'b0, 1'b1);
    step2(2'b01, 2'b10, 1'b1, 1'b1); exp2("seq1", 2'b00, 1'b1, 1'b1);
    step2(2'b10, 2'b11, 1'b0, 1'b1); exp2("seq2", 2'b01, 1'b1, 1'b1);
    step2(2'b11, 2'b10, 1'b1, 1'b1); exp2("seq3", 2'b10, 1'b1, 1'b1);
    step2(2'b00, 2'b11, 1'b0, 1'b1); exp2("seq4", 2'b11, 1'b0, 1'b1);

    // Full carry ripple, then signed overflow
    step2(2'b11, 2'b00, 1'b1, 1'b1); exp2("rip0", 2'b00, 1'b1, 1'b1);
    chk("rip0.ovf", 64'(if2.overflow), 64'd0);
    step2(2'b01, 2'b01, 1'b0, 1'b1); exp2("rip1", 2'b10, 1'b0, 1'b1);
    chk("rip1.ovf", 64'(if2.overflow), 64'd1);

    // Valid gating: previous result 00/c1 must hold while in_valid=0
    step2(2'b11, 2'b00, 1'b1, 1'b1); exp2("gate_pre", 2'b00, 1'b1, 1'b1);
    step2(2'b01, 2'b01, 1'b0, 1'b0); exp2("gate_off", 2'b00, 1'b1, 1'b0);
    chk("gate_off.ovf", 64'(if2.overflow), 64'd0);
    step2(2'b01, 2'b01, 1'b0, 1'b1); exp2("gate_on", 2'b10, 1'b0, 1'b1);
    chk("gate_on.ovf", 64'(if2.overflow), 64'd1);

    // Async reset between edges, right after a result is registered
    #2 rst = 1'b1;
    #1;
    exp2("arst", 2'b00, 1'b0, 1'b0);
    chk("arst.ovf", 64'(if2.overflow), 64'd0);
    step2(2'b11, 2'b11, 1'b1, 1'b1); exp2("arst_hold", 2'b00, 1'b0, 1'b0);
    rst = 1'b0;
    step2(2'b11, 2'b11, 1'b0, 1'b0); exp2("arst_idle", 2'b00, 1'b0, 1'b0);
    step2(2'b11, 2'b11, 1'b1, 1'b1); exp2("arst_first", 2'b11, 1'b1, 1'b1);

    // Exhaustive WIDTH=2, back-to-back
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int c = 0; c < 2; c++) begin
          a2 = 2'(a); b2 = 2'(b);
          step2(a2, b2, c[0], 1'b1);
          r2 = 3'(a + b + c);
          chk("ex2.sum_cout", 64'({if2.c_out, if2.sum}), 64'(r2));
          chk("ex2.ovf", 64'(if2.overflow), 64'(ovf_model(a, b, c, 2)));
          chk("ex2.vld", 64'(if2.out_valid), 64'd1);
        end
    if2.in_valid = 1'b0;

    // Exhaustive WIDTH=4, back-to-back
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++) begin
          a4 = 4'(a); b4 = 4'(b);
          if4.in_1 = a4; if4.in_2 = b4; if4.c_in = c[0]; if4.in_valid = 1'b1;
          @(posedge clk); #1;
          r4 = 5'(a + b + c);
          chk("ex4.sum_cout", 64'({if4.c_out, if4.sum}), 64'(r4));
          chk("ex4.ovf", 64'(if4.overflow), 64'(ovf_model(a, b, c, 4)));
          chk("ex4.vld", 64'(if4.out_valid), 64'd1);
        end
    if4.in_valid = 1'b0;

    // WIDTH=8 corners
    if8.in_1 = 8'hFF; if8.in_2 = 8'h01; if8.c_in = 1'b0; if8.in_valid = 1'b1;
    @(posedge clk); #1;
    chk("w8a.sum", 64'(if8.sum), 64'h00);
    chk("w8a.c_out", 64'(if8.c_out), 64'd1);
    chk("w8a.ovf", 64'(if8.overflow), 64'd0);
    if8.in_1 = 8'h7F; if8.in_2 = 8'h00; if8.c_in = 1'b1;
    @(posedge clk); #1;
    chk("w8b.sum", 64'(if8.sum), 64'h80);
    chk("w8b.c_out", 64'(if8.c_out), 64'd0);
    chk("w8b.ovf", 64'(if8.overflow), 64'd1);
    chk("w8b.vld", 64'(if8.out_valid), 64'd1);
    if8.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("w8c.vld", 64'(if8.out_valid), 64'd0);
    chk("w8c.sum", 64'(if8.sum), 64'h80);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
